// File: rtl/ibex_l2_xfer_ctrl.sv
// Bulk register transfer between the main RF and a single-port L2 register file (spill/fill).
// Optional checksum of transferred words is enabled by defining IBEX_L2_XFER_CSUM_EN.
module ibex_l2_xfer_ctrl #(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    input  logic                 req_op_i,
    output logic                 req_ready_o,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4:0]           rf_raddr_o,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic [4:0]           l2_addr_o,
    output logic [DataWidth-1:0] l2_wdata_o,
    output logic                 l2_we_o,
    input  logic [DataWidth-1:0] l2_rdata_i,
    output logic [DataWidth-1:0] csum_o
);

    localparam logic [4:0] NumRegs = RV32E ? 5'd15 : 5'd31;

    typedef enum logic [1:0] {StIdle, StSpill, StFill, StDone} state_e;

    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= 5'd1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        req_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        rf_raddr_o  = 5'd0;
        rf_waddr_o  = 5'd0;
        rf_wdata_o  = '0;
        rf_we_o     = 1'b0;
        l2_addr_o   = 5'd0;
        l2_wdata_o  = '0;
        l2_we_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                idx_d       = 5'd1;
                if (req_valid_i) begin
                    state_d = req_op_i ? StFill : StSpill;
                end
            end
            StSpill, StFill: begin
                busy_o = 1'b1;
                if (state_q == StSpill) begin
                    rf_raddr_o = idx_q;
                    l2_addr_o  = idx_q;
                    l2_wdata_o = rf_rdata_i;
                    l2_we_o    = 1'b1;
                end else begin
                    l2_addr_o  = idx_q;
                    rf_waddr_o = idx_q;
                    rf_wdata_o = l2_rdata_i;
                    rf_we_o    = 1'b1;
                end
                // The current word is always written; abort only stops further progress.
                if (abort_i) begin
                    state_d = StIdle;
                    idx_d   = 5'd1;
                end else if (idx_q == NumRegs) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            StDone: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = StIdle;
                idx_d   = 5'd1;
            end
            default: begin
                state_d = StIdle;
                idx_d   = 5'd1;
            end
        endcase
    end

`ifdef IBEX_L2_XFER_CSUM_EN
    logic [DataWidth-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == StIdle && req_valid_i) begin
            csum_d = '0;
        end else if (state_q == StSpill) begin
            csum_d = csum_q ^ rf_rdata_i;
        end else if (state_q == StFill) begin
            csum_d = csum_q ^ l2_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum_o = csum_q;
`else
    assign csum_o = '0;
`endif

endmodule

// File: doc/ibex_l2_xfer_ctrl.md
IBEX_L2_XFER_CTRL -- requirements
Module: ibex_l2_xfer_ctrl

Interface
REQ-001 The module SHALL have parameter DataWidth, default 32, giving the register word width.
REQ-002 The module SHALL have parameter RV32E, default 0, where 1 limits transfers to x1..x15 and 0 transfers x1..x31.
REQ-003 The module SHALL have port clk_i, input, 1 bit, the single clock.
REQ-004 The module SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port req_valid_i, input, 1 bit, transfer request.
REQ-006 The module SHALL have port req_op_i, input, 1 bit, operation select: 0 = spill (main RF to L2), 1 = fill (L2 to main RF).
REQ-007 The module SHALL have port req_ready_o, output, 1 bit, request accepted when high together with req_valid_i.
REQ-008 The module SHALL have port abort_i, input, 1 bit, cancel of the running transfer.
REQ-009 The module SHALL have port busy_o, output, 1 bit, transfer in progress.
REQ-010 The module SHALL have port done_o, output, 1 bit, one-cycle completion pulse.
REQ-011 The module SHALL have port rf_raddr_o, output, 5 bits, main RF read address.
REQ-012 The module SHALL have port rf_rdata_i, input, DataWidth bits, main RF read data, combinational from rf_raddr_o.
REQ-013 The module SHALL have ports rf_waddr_o (output, 5 bits), rf_wdata_o (output, DataWidth bits) and rf_we_o (output, 1 bit), the main RF write port.
REQ-014 The module SHALL have ports l2_addr_o (output, 5 bits), l2_wdata_o (output, DataWidth bits), l2_we_o (output, 1 bit) and l2_rdata_i (input, DataWidth bits), the single-port L2 register file interface with combinational read.
REQ-015 The module SHALL have port csum_o, output, DataWidth bits, transfer checksum.

Function
REQ-016 The FSM SHALL have the states IDLE, SPILL, FILL and DONE.
REQ-017 In IDLE, req_ready_o SHALL be 1; in all other states it SHALL be 0.
REQ-018 On req_valid_i && req_ready_o, the FSM SHALL go to SPILL or FILL per req_op_i, with the index counter at 1.
REQ-019 In SPILL, each cycle SHALL drive rf_raddr_o = l2_addr_o = index, l2_wdata_o = rf_rdata_i and l2_we_o = 1.
REQ-020 In FILL, each cycle SHALL drive l2_addr_o = rf_waddr_o = index, rf_wdata_o = l2_rdata_i and rf_we_o = 1.
REQ-021 Outside SPILL and FILL, l2_we_o and rf_we_o SHALL be 0, and all address outputs SHALL be 0.
REQ-022 The index SHALL increment by 1 per cycle; when it equals NumRegs (31, or 15 if RV32E) the FSM SHALL go to DONE the next cycle; the index SHALL never wrap past NumRegs and x0 SHALL never be addressed.
REQ-023 In DONE, done_o SHALL be 1 for exactly one cycle, followed by IDLE; accept-to-done SHALL be NumRegs+1 cycles (32 or 16).
REQ-024 busy_o SHALL be 1 in SPILL, FILL and DONE.
REQ-025 abort_i in SPILL or FILL SHALL let that cycle's transfer complete, then go to IDLE with no done_o; abort_i on the last index SHALL still suppress DONE.
REQ-026 abort_i in IDLE or DONE SHALL be ignored.
REQ-027 A request in the same cycle as DONE SHALL not be accepted.

Reset
REQ-028 When rst_ni is low, asynchronously: state SHALL be IDLE, index SHALL be 1 and csum SHALL be 0.
REQ-029 During reset, req_ready_o SHALL be 1, and busy_o, done_o, all write enables and all addresses SHALL be 0.
REQ-030 Reset during a transfer SHALL abandon it with no done_o; registers already written SHALL keep their values.

Configuration
REQ-031 With IBEX_L2_XFER_CSUM_EN defined, csum_o SHALL be the XOR of all words transferred since the last accept, cleared to 0 on accept and stable from DONE until the next accept.
REQ-032 Without IBEX_L2_XFER_CSUM_EN, csum_o SHALL be tied to 0 and no checksum register SHALL exist.

Verification
REQ-033 Spill case: main RF preloaded with xN = 0x1000_0000+N, RV32E=0, spill requested -> l2_we_o for 31 cycles at addresses 1..31 with matching data, done_o in cycle 32 after accept, and L2 then holds the same values.
REQ-034 Fill case: L2 preloaded with xN = ~N, fill requested -> rf_we_o for addresses 1..31, main RF then holds ~N, and neither interface's x0 is ever written.
REQ-035 Abort case: abort_i asserted in the cycle index = 10 -> addresses 1..10 written, 11..31 unchanged, no done_o, req_ready_o = 1 on the next cycle.
REQ-036 Back-to-back case: req_valid_i held high throughout -> the second request is accepted only in the cycle after the done_o pulse, and there is no acceptance while busy_o = 1.
REQ-037 RV32E=1 case: spill -> addresses 1..15 only, done_o 16 cycles after accept; with CSUM_EN, data xN = N gives csum_o = XOR(1..15) = 0x0000_0000.
REQ-038 Reset case: rst_ni pulsed low at index 5 of a fill -> all outputs immediately at reset values, and after release no done_o until a new request.
